wishbone_rr_arbiter: RTL and testbench
======================================

# wishbone_rr_arbiter

Round-robin arbiter that shares one Wishbone slave, typically `wishbone_slave_adapter` in front of a RAM, between N Wishbone masters, such as the RV32I instruction-fetch port, the data port and the NoC network interface. It has these duties:
- Grants the bus to one master per cycle-group and holds the grant until that master drops `CYC`.
- Routes `ACK` and read data back to the granted master only.
- Aborts any transfer whose slave fails to acknowledge within a programmable timeout, returning an error to the master.

## Interface
Parameters:
- NUM_MASTERS, 2: number of requesting masters, 2..8.
- TIMEOUT, 255: maximum cycles from slave `STB` to `ACK` before abort. Must be at least 4.

Ports. Per-master buses are flattened, with master k occupying slice [k*W +: W].
- clk_i  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- m_addr_i  in  NUM_MASTERS*32  master addresses.
- m_data_i  in  NUM_MASTERS*32  master write data.
- m_we_i  in  NUM_MASTERS  master write enables.
- m_sel_i  in  NUM_MASTERS*4  master byte selects.
- m_stb_i  in  NUM_MASTERS  master strobes.
- m_cyc_i  in  NUM_MASTERS  master cycles.
- m_data_o  out  32  read data, common to all masters; valid only alongside that master's ack.
- m_ack_o  out  NUM_MASTERS  per-master acknowledge.
- m_err_o  out  NUM_MASTERS  per-master timeout error.
- s_addr_o, s_data_o  out  32 each  to the slave.
- s_we_o  out  1  to the slave.
- s_sel_o  out  4  to the slave.
- s_stb_o, s_cyc_o  out  1 each  to the slave.
- s_data_i  in  32  slave read data.
- s_ack_i  in  1  slave acknowledge.
- gnt_o  out  NUM_MASTERS  one-hot current grant; all zero when idle. For debug and performance counters.

## Operation
- A master requests when `m_cyc_i[k]` is high.
- State machine:
  - IDLE: `s_cyc_o`, `s_stb_o`, `m_ack_o`, `m_err_o` and `gnt_o` are all 0. If any request is present, the winner is registered into `gnt` and the FSM moves to BUSY.
  - BUSY: slave outputs are muxed combinationally from the granted master.
    - `s_cyc_o` = `m_cyc_i[g]`.
    - `s_stb_o` = `m_stb_i[g]`, forced low in the abort cycle.
    - `m_ack_o[g]` = `s_ack_i`; every other ack bit is 0.
    - `m_data_o` = `s_data_i`.
    - When `m_cyc_i[g]` falls, the FSM returns to IDLE and the `last` pointer is set to g.
- Round-robin priority: search starts at (`last` + 1) mod NUM_MASTERS and takes the first requester found.
  - `last` resets to NUM_MASTERS-1, so master 0 wins the first contention.
  - There is no preemption; a granted master keeps the bus for any number of back-to-back transfers while it holds `CYC`.
- Timeout counter:
  - Cleared on entry to BUSY and on every `s_ack_i`.
  - Increments on each cycle where `s_stb_o` is high and `s_ack_i` is low.
  - When it reaches TIMEOUT, that cycle is the abort: `m_err_o[g]` = 1 for exactly 1 cycle, `s_stb_o` is forced to 0, and the counter clears.
  - The grant is kept until the master drops `CYC`.
- Counter width: $clog2(TIMEOUT+1); it saturates and never wraps.
- `s_ack_i` while IDLE is ignored: no `m_ack_o` bit asserts.
- `s_ack_i` and timeout in the same cycle: ack wins, and no err is raised.

## Timing
- Arbitration latency: 1 cycle. A request arriving in cycle t is granted with `s_cyc_o` high in t+1.
- Release: if `m_cyc_i[g]` falls in cycle t, `s_cyc_o` is low in t (combinational) and the FSM is IDLE in t+1. The next grant appears at t+2, so consecutive owners are separated by at least 1 idle bus cycle.
- Ack path is zero-latency and combinational, `s_ack_i` to `m_ack_o`. With the slave adapter's IDLE/ACK/COOLDOWN pattern, a single read completes in 3 cycles after grant.
- Asynchronous reset mid-transfer:
  - All outputs drop to 0 immediately.
  - `gnt` clears, `last` becomes NUM_MASTERS-1, the counter clears and the FSM goes to IDLE.
  - There is no pending ack or err after reset release.

## Structure
- Shared package `wb_pkg`: Wishbone widths (address 32, data 32, select 4), arbiter FSM state encoding (IDLE=1'b0, BUSY=1'b1) and the default TIMEOUT constant.
- One sub-module, `rr_priority_pick`: combinational. Inputs are the request vector and `last`; output is the one-hot winner. It is reusable by the NoC router output ports.
- The top level holds the FSM, `gnt`/`last` registers, the timeout counter and the output muxes.

## Test plan
- Reset: hold `rst` with all `m_cyc_i`=1. Required: `s_cyc_o`=0, `gnt_o`=0, `m_ack_o`=0. After release, `gnt_o`=2'b01 one cycle later.
- Single master: NUM_MASTERS=2, master 1 reads 0x0000_0040 from an adapter-backed RAM returning 0xDEADBEEF. Required: `m_ack_o`=2'b10 for 1 cycle and `m_data_o`=0xDEADBEEF; `m_ack_o[0]` is never high.
- Contention and fairness: both masters request continuously, each dropping `CYC` after 1 transfer. Required: grants alternate 01,10,01,10, with exactly 1 idle cycle between owners.
- Burst hold: master 0 holds `CYC` for 4 writes while master 1 requests. Required: master 1 is granted only after master 0 drops `CYC`, and all 4 writes are acked to master 0.
- Timeout: TIMEOUT=8 with a slave that never acks. Required: `m_err_o[g]`=1 exactly 8 cycles after `s_stb_o` rises, `s_stb_o` is low in that cycle, and the grant is released when the master drops `CYC`.
- Async reset mid-transfer: assert `rst` between slave `STB` and `ACK`. Required: outputs are 0 within the same cycle; after release a new request gives a normal transfer with no stale ack or err.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone widths, arbiter state encoding and default timeout.
package wb_pkg;

  localparam int WB_ADDR_W           = 32;
  localparam int WB_DATA_W           = 32;
  localparam int WB_SEL_W            = 4;
  localparam int ARB_TIMEOUT_DEFAULT = 255;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wishbone_rr_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first requester after 'last', returned one-hot.
module rr_priority_pick #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last,
  output logic [NUM_MASTERS-1:0] winner
);

  localparam logic [NUM_MASTERS-1:0] ONE = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

  int                     idx;
  logic [NUM_MASTERS-1:0] rot;

  // Walk the search order backwards so the nearest requester after 'last' is written last.
  always_comb begin
    winner = '0;
    idx    = 0;
    rot    = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      idx = int'(last) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      rot = req >> idx;
      if (rot[0]) winner = ONE << idx;
    end
  end

endmodule

// File: rtl/wishbone_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave between NUM_MASTERS masters,
// with a per-transfer ack timeout that returns an error to the granted master.
module wishbone_rr_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = ARB_TIMEOUT_DEFAULT
) (
  input  logic                             clk_i,
  input  logic                             rst,
  input  logic [NUM_MASTERS*WB_ADDR_W-1:0] m_addr_i,
  input  logic [NUM_MASTERS*WB_DATA_W-1:0] m_data_i,
  input  logic [NUM_MASTERS-1:0]           m_we_i,
  input  logic [NUM_MASTERS*WB_SEL_W-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]           m_stb_i,
  input  logic [NUM_MASTERS-1:0]           m_cyc_i,
  output logic [WB_DATA_W-1:0]             m_data_o,
  output logic [NUM_MASTERS-1:0]           m_ack_o,
  output logic [NUM_MASTERS-1:0]           m_err_o,
  output logic [WB_ADDR_W-1:0]             s_addr_o,
  output logic [WB_DATA_W-1:0]             s_data_o,
  output logic                             s_we_o,
  output logic [WB_SEL_W-1:0]              s_sel_o,
  output logic                             s_stb_o,
  output logic                             s_cyc_o,
  input  logic [WB_DATA_W-1:0]             s_data_i,
  input  logic                             s_ack_i,
  output logic [NUM_MASTERS-1:0]           gnt_o
);

  localparam int                IDX_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NUM_MASTERS - 1);

  arb_state_e             state, state_d;
  logic [NUM_MASTERS-1:0] gnt, gnt_d, winner;
  logic [IDX_W-1:0]       gidx, gidx_d, last, last_d, widx;
  logic [CNT_W-1:0]       cnt;
  logic                   busy, stb_g, abort;

  rr_priority_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_pick (
    .req    (m_cyc_i),
    .last   (last),
    .winner (winner)
  );

  always_comb begin
    widx = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (winner[k]) widx = IDX_W'(k);
    end
  end

  assign busy  = (state == ARB_BUSY);
  assign stb_g = busy & m_stb_i[gidx];
  // An ack arriving in the timeout cycle completes the transfer instead of aborting it.
  assign abort = busy & (cnt == CNT_MAX) & ~s_ack_i;

  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    gidx_d  = gidx;
    last_d  = last;
    case (state)
      ARB_IDLE: begin
        if (|m_cyc_i) begin
          state_d = ARB_BUSY;
          gnt_d   = winner;
          gidx_d  = widx;
        end
      end
      ARB_BUSY: begin
        if (!m_cyc_i[gidx]) begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
          last_d  = gidx;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      gnt   <= '0;
      gidx  <= '0;
      last  <= LAST_RST;
    end else begin
      state <= state_d;
      gnt   <= gnt_d;
      gidx  <= gidx_d;
      last  <= last_d;
    end
  end

  // Held at zero while idle, so every grant starts its first strobe from a clean count.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!busy || s_ack_i || abort) begin
      cnt <= '0;
    end else if (s_stb_o && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign s_cyc_o  = busy & m_cyc_i[gidx];
  assign s_stb_o  = stb_g & ~abort;
  assign s_addr_o = busy ? m_addr_i[gidx*WB_ADDR_W +: WB_ADDR_W] : '0;
  assign s_data_o = busy ? m_data_i[gidx*WB_DATA_W +: WB_DATA_W] : '0;
  assign s_sel_o  = busy ? m_sel_i[gidx*WB_SEL_W +: WB_SEL_W] : '0;
  assign s_we_o   = busy & m_we_i[gidx];
  assign m_data_o = busy ? s_data_i : '0;
  assign m_ack_o  = gnt & {NUM_MASTERS{s_ack_i}};
  assign m_err_o  = gnt & {NUM_MASTERS{abort}};
  assign gnt_o    = gnt;

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Directed bench for wishbone_rr_arbiter: two masters, TIMEOUT=8.
module tb_wishbone_rr_arbiter;

  logic        clk_i = 1'b0;
  logic        rst;
  logic [63:0] m_addr_i;
  logic [63:0] m_data_i;
  logic [1:0]  m_we_i;
  logic [7:0]  m_sel_i;
  logic [1:0]  m_stb_i;
  logic [1:0]  m_cyc_i;
  logic [31:0] m_data_o;
  logic [1:0]  m_ack_o;
  logic [1:0]  m_err_o;
  logic [31:0] s_addr_o;
  logic [31:0] s_data_o;
  logic        s_we_o;
  logic [3:0]  s_sel_o;
  logic        s_stb_o;
  logic        s_cyc_o;
  logic [31:0] s_data_i;
  logic        s_ack_i;
  logic [1:0]  gnt_o;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [1:0] cyc;
    logic [1:0] stb;
    logic       ack;
    logic [1:0] gnt;
    logic       scyc;
    logic       sstb;
    logic [1:0] mack;
    logic [1:0] merr;
  } vec_t;

  vec_t tbl [31];

  wishbone_rr_arbiter #(
    .NUM_MASTERS (2),
    .TIMEOUT     (8)
  ) dut (
    .clk_i    (clk_i),
    .rst      (rst),
    .m_addr_i (m_addr_i),
    .m_data_i (m_data_i),
    .m_we_i   (m_we_i),
    .m_sel_i  (m_sel_i),
    .m_stb_i  (m_stb_i),
    .m_cyc_i  (m_cyc_i),
    .m_data_o (m_data_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .s_addr_o (s_addr_o),
    .s_data_o (s_data_o),
    .s_we_o   (s_we_o),
    .s_sel_o  (s_sel_o),
    .s_stb_o  (s_stb_o),
    .s_cyc_o  (s_cyc_o),
    .s_data_i (s_data_i),
    .s_ack_i  (s_ack_i),
    .gnt_o    (gnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock, drive the new inputs just after the edge, settle to the falling edge.
  task automatic step(input logic [1:0] cyc, input logic [1:0] stb, input logic ack);
    @(posedge clk_i);
    #1;
    m_cyc_i = cyc;
    m_stb_i = stb;
    s_ack_i = ack;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    m_cyc_i = 2'b00;
    m_stb_i = 2'b00;
    s_ack_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst = 1'b0;
  endtask

  task automatic chk_mux(input string tag, input logic [1:0] g);
    logic [31:0] ea, ed;
    logic [3:0]  es;
    ea = (g == 2'b01) ? 32'h0000_0100 : (g == 2'b10) ? 32'h0000_0040 : 32'h0;
    ed = (g != 2'b00) ? 32'hDEAD_BEEF : 32'h0;
    es = (g == 2'b01) ? 4'h3 : (g == 2'b10) ? 4'hC : 4'h0;
    chk({tag, " s_addr"}, s_addr_o, ea);
    chk({tag, " m_data"}, m_data_o, ed);
    chk({tag, " s_sel"}, {28'h0, s_sel_o}, {28'h0, es});
    chk({tag, " s_we"}, {31'h0, s_we_o}, {31'h0, (g == 2'b01)});
  endtask

  initial begin
    m_addr_i = {32'h0000_0040, 32'h0000_0100};
    m_data_i = {32'h1111_1111, 32'hA5A5_0000};
    m_we_i   = 2'b01;
    m_sel_i  = {4'hC, 4'h3};
    s_data_i = 32'hDEAD_BEEF;

    // Reset held with every master requesting and a stray slave ack.
    rst     = 1'b1;
    m_cyc_i = 2'b11;
    m_stb_i = 2'b11;
    s_ack_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst s_cyc", {31'h0, s_cyc_o}, 32'h0);
    chk("rst s_stb", {31'h0, s_stb_o}, 32'h0);
    chk("rst gnt",   {30'h0, gnt_o},   32'h0);
    chk("rst ack",   {30'h0, m_ack_o}, 32'h0);
    chk("rst err",   {30'h0, m_err_o}, 32'h0);
    @(posedge clk_i);
    #1;
    rst     = 1'b0;
    s_ack_i = 1'b0;
    m_stb_i = 2'b00;
    @(negedge clk_i);
    chk("release gnt", {30'h0, gnt_o}, 32'h0);
    step(2'b11, 2'b00, 1'b0);
    chk("first gnt",   {30'h0, gnt_o}, 32'h1);
    chk("first s_cyc", {31'h0, s_cyc_o}, 32'h1);

    // cyc, stb, ack | gnt, s_cyc, s_stb, m_ack, m_err
    tbl = '{
      '{2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00},  // m1 single read
      '{2'b10, 2'b10, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 2'b00},
      '{2'b10, 2'b10, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10, 2'b00},
      '{2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00},
      '{2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00},  // contention
      '{2'b11, 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00},
      '{2'b11, 2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 2'b00},
      '{2'b10, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00},
      '{2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00},
      '{2'b11, 2'b10, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 2'b00},
      '{2'b11, 2'b10, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10, 2'b00},
      '{2'b01, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00},
      '{2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00},
      '{2'b11, 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00},
      '{2'b11, 2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 2'b00},
      '{2'b10, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00},
      '{2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00},
      '{2'b10, 2'b10, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 2'b00},
      '{2'b10, 2'b10, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10, 2'b00},
      '{2'b01, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00},
      '{2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00},  // m0 burst of 4 writes
      '{2'b11, 2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 2'b00},
      '{2'b11, 2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 2'b00},
      '{2'b11, 2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00},
      '{2'b11, 2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 2'b00},
      '{2'b11, 2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 2'b00},
      '{2'b10, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00},
      '{2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00},
      '{2'b10, 2'b10, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 2'b00},
      '{2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00},
      '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00}   // ack while idle
    };

    do_reset();
    for (int i = 0; i < 31; i++) begin
      string tag;
      tag = $sformatf("row%0d", i);
      step(tbl[i].cyc, tbl[i].stb, tbl[i].ack);
      chk({tag, " gnt"},   {30'h0, gnt_o},   {30'h0, tbl[i].gnt});
      chk({tag, " s_cyc"}, {31'h0, s_cyc_o}, {31'h0, tbl[i].scyc});
      chk({tag, " s_stb"}, {31'h0, s_stb_o}, {31'h0, tbl[i].sstb});
      chk({tag, " m_ack"}, {30'h0, m_ack_o}, {30'h0, tbl[i].mack});
      chk({tag, " m_err"}, {30'h0, m_err_o}, {30'h0, tbl[i].merr});
      chk_mux(tag, tbl[i].gnt);
    end

    // Timeout: slave never acks; abort lands 8 cycles after s_stb_o rises.
    do_reset();
    step(2'b01, 2'b01, 1'b0);
    chk("to idle gnt", {30'h0, gnt_o}, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      step(2'b01, 2'b01, 1'b0);
      chk($sformatf("to wait%0d s_stb", i), {31'h0, s_stb_o}, 32'h1);
      chk($sformatf("to wait%0d err", i),   {30'h0, m_err_o}, 32'h0);
    end
    step(2'b01, 2'b01, 1'b0);
    chk("to abort err",   {30'h0, m_err_o}, 32'h1);
    chk("to abort s_stb", {31'h0, s_stb_o}, 32'h0);
    chk("to abort gnt",   {30'h0, gnt_o},   32'h1);
    chk("to abort s_cyc", {31'h0, s_cyc_o}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      step(2'b01, 2'b01, 1'b0);
      chk($sformatf("to rewait%0d err", i), {30'h0, m_err_o}, 32'h0);
    end
    // Ack arrives in the very cycle the counter hits the limit.
    step(2'b01, 2'b01, 1'b1);
    chk("to ackwin ack",   {30'h0, m_ack_o}, 32'h1);
    chk("to ackwin err",   {30'h0, m_err_o}, 32'h0);
    chk("to ackwin s_stb", {31'h0, s_stb_o}, 32'h1);
    step(2'b01, 2'b01, 1'b0);
    chk("to after err",   {30'h0, m_err_o}, 32'h0);
    chk("to after s_stb", {31'h0, s_stb_o}, 32'h1);
    step(2'b00, 2'b00, 1'b0);
    chk("to drop s_cyc", {31'h0, s_cyc_o}, 32'h0);
    chk("to drop gnt",   {30'h0, gnt_o},   32'h1);
    step(2'b00, 2'b00, 1'b0);
    chk("to released gnt", {30'h0, gnt_o}, 32'h0);

    // Async reset mid-transfer; 'last' is 0 beforehand so a restored pointer favours master 0.
    do_reset();
    step(2'b01, 2'b01, 1'b0);
    step(2'b01, 2'b01, 1'b0);
    step(2'b01, 2'b01, 1'b1);
    chk("ar pre ack", {30'h0, m_ack_o}, 32'h1);
    step(2'b00, 2'b00, 1'b0);
    step(2'b01, 2'b01, 1'b0);
    step(2'b01, 2'b01, 1'b0);
    chk("ar busy gnt", {30'h0, gnt_o}, 32'h1);
    #1;
    rst     = 1'b1;
    s_ack_i = 1'b1;
    #1;
    chk("ar s_cyc",  {31'h0, s_cyc_o}, 32'h0);
    chk("ar s_stb",  {31'h0, s_stb_o}, 32'h0);
    chk("ar gnt",    {30'h0, gnt_o},   32'h0);
    chk("ar ack",    {30'h0, m_ack_o}, 32'h0);
    chk("ar err",    {30'h0, m_err_o}, 32'h0);
    chk("ar s_addr", s_addr_o, 32'h0);
    @(posedge clk_i);
    #1;
    rst     = 1'b0;
    m_cyc_i = 2'b11;
    m_stb_i = 2'b00;
    s_ack_i = 1'b0;
    @(negedge clk_i);
    chk("ar rel gnt", {30'h0, gnt_o},   32'h0);
    chk("ar rel ack", {30'h0, m_ack_o}, 32'h0);
    chk("ar rel err", {30'h0, m_err_o}, 32'h0);
    step(2'b11, 2'b01, 1'b0);
    chk("ar new gnt",   {30'h0, gnt_o},   32'h1);
    chk("ar new s_stb", {31'h0, s_stb_o}, 32'h1);
    chk("ar new ack",   {30'h0, m_ack_o}, 32'h0);
    step(2'b11, 2'b01, 1'b1);
    chk("ar new ack2", {30'h0, m_ack_o}, 32'h1);
    chk("ar new data", m_data_o, 32'hDEAD_BEEF);
    chk("ar new err",  {30'h0, m_err_o}, 32'h0);
    step(2'b10, 2'b00, 1'b0);
    chk("ar end s_cyc", {31'h0, s_cyc_o}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
